// File: rtl/corvex_mem_model_pkg.sv
// Shared types for the Avalon-MM memory model: FSM state encoding and the
// Avalon response codes returned on m_response.
package corvex_mem_model_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RLAT   = 2'd1,
        RBURST = 2'd2,
        WBURST = 2'd3
    } state_t;

    localparam logic [1:0] RESP_OKAY        = 2'b00;
    localparam logic [1:0] RESP_SLAVEERROR  = 2'b10;
    localparam logic [1:0] RESP_DECODEERROR = 2'b11;

endpackage : corvex_mem_model_pkg

// File: rtl/corvex_mem_model_array.sv
// Word storage for the memory model: one bus write port with per-byte
// enables, one full-word backdoor write port and one asynchronous read port.
// A backdoor write wins over a bus write to the same word in the same cycle.
module corvex_mem_model_array #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 32768,
    parameter int IDX_W       = 15
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                bd_we,
    input  logic [IDX_W-1:0]    bd_idx,
    input  logic [DATA_W-1:0]   bd_data,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [DATA_W-1:0]   rd_data
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Byte-lane bus write first, backdoor last so it takes priority.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < DATA_W / 8; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
        if (bd_we) begin
            mem[bd_idx] <= bd_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule : corvex_mem_model_array

// File: rtl/corvex_avalon_mem_model.sv
// Avalon-MM burst-capable slave memory model with configurable read latency,
// backdoor preload, out-of-range decode errors and protocol checking.
// Optional per-word error map enabled by macro CORVEX_MEM_MODEL_ERRMAP_EN.
module corvex_avalon_mem_model
    import corvex_mem_model_pkg::*;
#(
    parameter int ADDR_W       = 34,
    parameter int DATA_W       = 32,
    parameter int DEPTH_WORDS  = 32768,
    parameter int READ_LATENCY = 1,
    parameter int BURST_W      = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   m_address,
    input  logic [BURST_W-1:0]  m_burstcount,
    input  logic                m_read,
    input  logic                m_write,
    input  logic [DATA_W-1:0]   m_writedata,
    input  logic [DATA_W/8-1:0] m_byteenable,
    output logic                m_waitrequest,
    output logic [DATA_W-1:0]   m_readdata,
    output logic                m_readdatavalid,
    output logic [1:0]          m_response,
    input  logic                bd_we,
    input  logic [31:0]         bd_index,
    input  logic [DATA_W-1:0]   bd_data,
    input  logic                bd_err_we,
    input  logic                bd_err,
    output logic                proto_err,
    output logic [15:0]         err_write_cnt
);

    localparam int BYTES   = DATA_W / 8;
    localparam int BYTE_SH = (BYTES > 1) ? $clog2(BYTES) : 0;
    // One spare bit so base word + beat offset never wraps.
    localparam int WIDX_W  = ADDR_W - BYTE_SH + 1;
    localparam int IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [2:0] LAT_LAST = 3'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

    state_t              state, state_n;
    logic [WIDX_W-1:0]   base_q, base_n;
    logic [BURST_W-1:0]  len_q, len_n;
    logic [BURST_W-1:0]  beat_q, beat_n;
    logic [2:0]          lat_q, lat_n;
    logic                proto_set;

    logic [WIDX_W-1:0]   acc_word;
    logic [BURST_W-1:0]  acc_len;
    logic [WIDX_W-1:0]   cur_word;

    logic                wr_beat;
    logic [WIDX_W-1:0]   wr_word;
    logic                wr_oor;
    logic                wr_errbit;
    logic                wr_drop;

    logic                rd_oor;
    logic                rd_errbit;
    logic [1:0]          rd_resp;
    logic [DATA_W-1:0]   rd_data;

    logic                bd_in_range;

    assign acc_word    = WIDX_W'(m_address >> BYTE_SH);
    assign acc_len     = (m_burstcount == '0) ? BURST_W'(1) : m_burstcount;
    assign cur_word    = base_q + WIDX_W'(beat_q);
    assign bd_in_range = (bd_index < 32'(DEPTH_WORDS));

    assign wr_oor  = (wr_word >= WIDX_W'(DEPTH_WORDS));
    assign wr_drop = wr_oor | wr_errbit;
    assign rd_oor  = (cur_word >= WIDX_W'(DEPTH_WORDS));

    assign m_waitrequest = (state == RLAT) || (state == RBURST);

    // Storage: bus writes are suppressed in reset and for dropped beats.
    corvex_mem_model_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_beat & ~wr_drop & ~rst),
        .wr_idx  (wr_word[IDX_W-1:0]),
        .wr_data (m_writedata),
        .wr_be   (m_byteenable),
        .bd_we   (bd_we & bd_in_range),
        .bd_idx  (bd_index[IDX_W-1:0]),
        .bd_data (bd_data),
        .rd_idx  (cur_word[IDX_W-1:0]),
        .rd_data (rd_data)
    );

`ifdef CORVEX_MEM_MODEL_ERRMAP_EN
    logic err_map [DEPTH_WORDS];

    // Error map is preload-only state: untouched by rst.
    always_ff @(posedge clk) begin
        if (bd_err_we && bd_in_range) begin
            err_map[bd_index[IDX_W-1:0]] <= bd_err;
        end
    end

    assign wr_errbit = !wr_oor && err_map[wr_word[IDX_W-1:0]];
    assign rd_errbit = !rd_oor && err_map[cur_word[IDX_W-1:0]];
`else
    logic unused_errmap;
    assign unused_errmap = bd_err_we ^ bd_err;
    assign wr_errbit     = 1'b0;
    assign rd_errbit     = 1'b0;
`endif

    // Per-beat read response: decode error dominates slave error.
    always_comb begin
        rd_resp = RESP_OKAY;
        if (rd_oor) begin
            rd_resp = RESP_DECODEERROR;
        end else if (rd_errbit) begin
            rd_resp = RESP_SLAVEERROR;
        end
    end

    // Next-state, burst bookkeeping and bus write strobe.
    always_comb begin
        state_n   = state;
        base_n    = base_q;
        len_n     = len_q;
        beat_n    = beat_q;
        lat_n     = lat_q;
        proto_set = 1'b0;
        wr_beat   = 1'b0;
        wr_word   = cur_word;
        unique case (state)
            IDLE: begin
                if (m_read) begin
                    proto_set = m_write;
                    base_n    = acc_word;
                    len_n     = acc_len;
                    beat_n    = '0;
                    lat_n     = '0;
                    state_n   = (READ_LATENCY > 1) ? RLAT : RBURST;
                end else if (m_write) begin
                    wr_beat = 1'b1;
                    wr_word = acc_word;
                    base_n  = acc_word;
                    len_n   = acc_len;
                    if (acc_len == BURST_W'(1)) begin
                        beat_n  = '0;
                        state_n = IDLE;
                    end else begin
                        beat_n  = BURST_W'(1);
                        state_n = WBURST;
                    end
                end
            end
            RLAT: begin
                if (lat_q == LAT_LAST) begin
                    lat_n   = '0;
                    state_n = RBURST;
                end else begin
                    lat_n = lat_q + 3'd1;
                end
            end
            RBURST: begin
                if (beat_q == len_q - BURST_W'(1)) begin
                    beat_n  = '0;
                    state_n = IDLE;
                end else begin
                    beat_n = beat_q + BURST_W'(1);
                end
            end
            WBURST: begin
                proto_set = m_read;
                if (m_write) begin
                    wr_beat = 1'b1;
                    if (beat_q == len_q - BURST_W'(1)) begin
                        beat_n  = '0;
                        state_n = IDLE;
                    end else begin
                        beat_n = beat_q + BURST_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // FSM state and burst/latency counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            base_q <= '0;
            len_q  <= '0;
            beat_q <= '0;
            lat_q  <= '0;
        end else begin
            state  <= state_n;
            base_q <= base_n;
            len_q  <= len_n;
            beat_q <= beat_n;
            lat_q  <= lat_n;
        end
    end

    // Read return path: one registered beat per RBURST cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_readdatavalid <= 1'b0;
            m_response      <= RESP_DECODEERROR;
            m_readdata      <= '0;
        end else if (state == RBURST) begin
            m_readdatavalid <= 1'b1;
            m_response      <= rd_resp;
            m_readdata      <= (rd_resp == RESP_OKAY) ? rd_data : '0;
        end else begin
            m_readdatavalid <= 1'b0;
            m_response      <= RESP_DECODEERROR;
        end
    end

    // Sticky protocol error flag and saturating dropped-write counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err     <= 1'b0;
            err_write_cnt <= '0;
        end else begin
            if (proto_set) begin
                proto_err <= 1'b1;
            end
            if (wr_beat && wr_drop && (err_write_cnt != 16'hFFFF)) begin
                err_write_cnt <= err_write_cnt + 16'd1;
            end
        end
    end

endmodule : corvex_avalon_mem_model

// File: tb/tb_corvex_avalon_mem_model.sv
// Directed bench for corvex_avalon_mem_model: a latency-1 instance for the
// functional vectors and a latency-3 instance for burst timing.
module tb_corvex_avalon_mem_model;

    import corvex_mem_model_pkg::*;

`ifdef CORVEX_MEM_MODEL_ERRMAP_EN
    localparam bit ERRMAP = 1'b1;
`else
    localparam bit ERRMAP = 1'b0;
`endif

    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic [33:0] m_address;
    logic [4:0]  m_burstcount;
    logic        m_read1, m_write1, m_read3, m_write3;
    logic [31:0] m_writedata;
    logic [3:0]  m_byteenable;
    logic        bd_we, bd_err_we, bd_err;
    logic [31:0] bd_index, bd_data;

    logic        wait1, valid1, perr1, wait3, valid3, perr3;
    logic [31:0] rdata1, rdata3;
    logic [1:0]  resp1, resp3;
    logic [15:0] ecnt1, ecnt3;

    always #5 clk = ~clk;

    corvex_avalon_mem_model #(
        .ADDR_W(34), .DATA_W(32), .DEPTH_WORDS(DEPTH), .READ_LATENCY(1), .BURST_W(5)
    ) u_dut (
        .clk(clk), .rst(rst), .m_address(m_address), .m_burstcount(m_burstcount),
        .m_read(m_read1), .m_write(m_write1), .m_writedata(m_writedata),
        .m_byteenable(m_byteenable), .m_waitrequest(wait1), .m_readdata(rdata1),
        .m_readdatavalid(valid1), .m_response(resp1), .bd_we(bd_we), .bd_index(bd_index),
        .bd_data(bd_data), .bd_err_we(bd_err_we), .bd_err(bd_err),
        .proto_err(perr1), .err_write_cnt(ecnt1)
    );

    corvex_avalon_mem_model #(
        .ADDR_W(34), .DATA_W(32), .DEPTH_WORDS(DEPTH), .READ_LATENCY(3), .BURST_W(5)
    ) u_dut3 (
        .clk(clk), .rst(rst), .m_address(m_address), .m_burstcount(m_burstcount),
        .m_read(m_read3), .m_write(m_write3), .m_writedata(m_writedata),
        .m_byteenable(m_byteenable), .m_waitrequest(wait3), .m_readdata(rdata3),
        .m_readdatavalid(valid3), .m_response(resp3), .bd_we(bd_we), .bd_index(bd_index),
        .bd_data(bd_data), .bd_err_we(bd_err_we), .bd_err(bd_err),
        .proto_err(perr3), .err_write_cnt(ecnt3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int          ncap, first_cyc;
    logic [31:0] cap_d [16];
    logic [1:0]  cap_r [16];
    int          cap_c [16];
    logic        wait_hist [64];
    logic        post_valid, post_wait;
    logic [31:0] wbuf [8];

    typedef struct {
        bit          is_wr;
        logic [33:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
    } vec_t;

    vec_t vt [13];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Backdoor preload; also clears the word's error bit.
    task automatic bd_write(input int idx, input logic [31:0] d);
        bd_we = 1'b1; bd_err_we = 1'b1; bd_err = 1'b0;
        bd_index = 32'(idx); bd_data = d;
        @(posedge clk); #1;
        bd_we = 1'b0; bd_err_we = 1'b0;
    endtask

    task automatic bd_seterr(input int idx, input logic e);
        bd_err_we = 1'b1; bd_err = e; bd_index = 32'(idx);
        @(posedge clk); #1;
        bd_err_we = 1'b0;
    endtask

    // Issue a read burst and capture beats; cycle 0 is the sample right after the accept edge.
    task automatic do_read(input bit on3, input logic [33:0] addr, input int bc);
        m_address = addr; m_burstcount = 5'(bc);
        if (on3) m_read3 = 1'b1; else m_read1 = 1'b1;
        @(posedge clk); #1;
        m_read1 = 1'b0; m_read3 = 1'b0;
        ncap = 0; first_cyc = -1;
        for (int cyc = 0; cyc < 64; cyc++) begin
            if (cyc > 0) begin @(posedge clk); #1; end
            wait_hist[cyc] = on3 ? wait3 : wait1;
            if (on3 ? valid3 : valid1) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (ncap < 16) begin
                    cap_d[ncap] = on3 ? rdata3 : rdata1;
                    cap_r[ncap] = on3 ? resp3 : resp1;
                    cap_c[ncap] = cyc;
                end
                ncap++;
                if (ncap >= bc) break;
            end
        end
        @(posedge clk); #1;
        post_valid = on3 ? valid3 : valid1;
        post_wait  = on3 ? wait3 : wait1;
    endtask

    // Write burst on the latency-1 instance; optional one-cycle stall after beat stall_after.
    task automatic do_write(input logic [33:0] addr, input int bc, input logic [3:0] be,
                            input int stall_after);
        m_address = addr; m_burstcount = 5'(bc); m_byteenable = be;
        for (int k = 0; k < bc; k++) begin
            m_writedata = wbuf[k]; m_write1 = 1'b1;
            @(posedge clk); #1;
            m_write1 = 1'b0;
            if (k == stall_after) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        int nv;
        rst = 1'b1; m_address = '0; m_burstcount = '0;
        m_read1 = 1'b0; m_write1 = 1'b0; m_read3 = 1'b0; m_write3 = 1'b0;
        m_writedata = '0; m_byteenable = '0;
        bd_we = 1'b0; bd_err_we = 1'b0; bd_err = 1'b0; bd_index = '0; bd_data = '0;

        vt[0]  = '{1'b0, 34'h1000, 32'h0,        4'h0, 32'hDEADBEAF, RESP_OKAY};
        vt[1]  = '{1'b0, 34'h1003, 32'h0,        4'h0, 32'hDEADBEAF, RESP_OKAY};
        vt[2]  = '{1'b1, 34'h1018, 32'h00ADBEAF, 4'h3, 32'h0,        RESP_OKAY};
        vt[3]  = '{1'b0, 34'h1018, 32'h0,        4'h0, 32'hFFFFBEAF, RESP_OKAY};
        vt[4]  = '{1'b1, 34'h101C, 32'hA5A5A5A5, 4'hC, 32'h0,        RESP_OKAY};
        vt[5]  = '{1'b0, 34'h101C, 32'h0,        4'h0, 32'hA5A50000, RESP_OKAY};
        vt[6]  = '{1'b1, 34'h101C, 32'h11223344, 4'h0, 32'h0,        RESP_OKAY};
        vt[7]  = '{1'b0, 34'h101C, 32'h0,        4'h0, 32'hA5A50000, RESP_OKAY};
        vt[8]  = '{1'b1, 34'h101E, 32'h11223344, 4'hF, 32'h0,        RESP_OKAY};
        vt[9]  = '{1'b0, 34'h101C, 32'h0,        4'h0, 32'h11223344, RESP_OKAY};
        vt[10] = '{1'b0, 34'h4000, 32'h0,        4'h0, 32'h0,        RESP_DECODEERROR};
        vt[11] = '{1'b0, 34'h1004, 32'h0,        4'h0, 32'h12345678, RESP_OKAY};
        vt[12] = '{1'b0, 34'h4004, 32'h0,        4'h0, 32'h0,        RESP_DECODEERROR};

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(valid1), 32'd0);
        check("rst_resp", 32'(resp1), 32'(RESP_DECODEERROR));
        check("rst_rdata", rdata1, 32'h0);
        check("rst_wait", 32'(wait1), 32'd0);
        check("rst_proto", 32'(perr1), 32'd0);
        check("rst_ecnt", 32'(ecnt1), 32'd0);
        check("rst_resp3", 32'(resp3), 32'(RESP_DECODEERROR));

        // Preload under reset: backdoor must still work.
        bd_write(0, 32'hBAD0BAD0);
        rst = 1'b0;
        bd_write(1024, 32'hDEADBEAF);
        bd_write(1025, 32'h12345678);
        bd_write(1030, 32'hFFFFFFFF);
        bd_write(1031, 32'h00000000);
        bd_write(1032, 32'h0);
        bd_write(1033, 32'h0);
        bd_write(1040, 32'h0);
        for (int k = 0; k < 4; k++) bd_write(2048 + k, 32'hA0000000 + 32'(k));

        // Single-beat vector table.
        for (int i = 0; i < 13; i++) begin
            if (vt[i].is_wr) begin
                wbuf[0] = vt[i].wdata;
                do_write(vt[i].addr, 1, vt[i].be, -1);
            end else begin
                do_read(1'b0, vt[i].addr, 1);
                check($sformatf("tbl%0d_beats", i), 32'(ncap), 32'd1);
                check($sformatf("tbl%0d_lat", i), 32'(first_cyc), 32'd1);
                check($sformatf("tbl%0d_data", i), cap_d[0], vt[i].exp_d);
                check($sformatf("tbl%0d_resp", i), 32'(cap_r[0]), 32'(vt[i].exp_r));
            end
        end

        // Latency 3, burst of 4.
        do_read(1'b1, 34'h2000, 4);
        check("lat3_beats", 32'(ncap), 32'd4);
        check("lat3_first", 32'(first_cyc), 32'd3);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("lat3_data%0d", k), cap_d[k], 32'hA0000000 + 32'(k));
            check($sformatf("lat3_resp%0d", k), 32'(cap_r[k]), 32'(RESP_OKAY));
            check($sformatf("lat3_cyc%0d", k), 32'(cap_c[k]), 32'(3 + k));
        end
        nv = 0;
        for (int c = 0; c < 6; c++) if (wait_hist[c]) nv++;
        check("lat3_wait_hi", 32'(nv), 32'd6);
        check("lat3_post_wait", 32'(post_wait), 32'd0);
        check("lat3_post_valid", 32'(post_valid), 32'd0);

        // Write burst of 2 with a stall, then read back as a burst.
        wbuf[0] = 32'h01010101; wbuf[1] = 32'h02020202;
        do_write(34'h1020, 2, 4'hF, 0);
        do_read(1'b0, 34'h1020, 2);
        check("wb_beats", 32'(ncap), 32'd2);
        check("wb_data0", cap_d[0], 32'h01010101);
        check("wb_data1", cap_d[1], 32'h02020202);

        // Backdoor beats a same-cycle bus write to the same word.
        m_address = 34'h1040; m_burstcount = 5'd1; m_byteenable = 4'hF;
        m_writedata = 32'h11111111; m_write1 = 1'b1;
        bd_we = 1'b1; bd_index = 32'd1040; bd_data = 32'h0BD0BD00;
        @(posedge clk); #1;
        m_write1 = 1'b0; bd_we = 1'b0;
        do_read(1'b0, 34'h1040, 1);
        check("bd_prio", cap_d[0], 32'h0BD0BD00);

        // Protocol error: read and write together is a read.
        m_address = 34'h1000; m_burstcount = 5'd1; m_writedata = 32'h99999999;
        m_byteenable = 4'hF; m_read1 = 1'b1; m_write1 = 1'b1;
        @(posedge clk); #1;
        m_read1 = 1'b0; m_write1 = 1'b0;
        check("proto_set", 32'(perr1), 32'd1);
        nv = 0;
        for (int c = 0; c < 10 && nv == 0; c++) begin
            @(posedge clk); #1;
            if (valid1) begin nv = 1; check("proto_rdata", rdata1, 32'hDEADBEAF); end
        end
        check("proto_read_seen", 32'(nv), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("proto_sticky", 32'(perr1), 32'd1);

        // Error map and discarded writes.
        bd_seterr(1025, 1'b1);
        do_read(1'b0, 34'h1000, 2);
        check("err_beats", 32'(ncap), 32'd2);
        check("err_resp0", 32'(cap_r[0]), 32'(RESP_OKAY));
        check("err_data0", cap_d[0], 32'hDEADBEAF);
        check("err_resp1", 32'(cap_r[1]), ERRMAP ? 32'(RESP_SLAVEERROR) : 32'(RESP_OKAY));
        check("err_data1", cap_d[1], ERRMAP ? 32'h0 : 32'h12345678);
        wbuf[0] = 32'hCAFEF00D;
        do_write(34'h1004, 1, 4'hF, -1);
        check("err_cnt1", 32'(ecnt1), ERRMAP ? 32'd1 : 32'd0);
        wbuf[0] = 32'h55555555;
        do_write(34'h4000, 1, 4'hF, -1);
        check("err_cnt_oor", 32'(ecnt1), ERRMAP ? 32'd2 : 32'd1);
        bd_seterr(1025, 1'b0);
        do_read(1'b0, 34'h1004, 1);
        check("err_contents", cap_d[0], ERRMAP ? 32'h12345678 : 32'hCAFEF00D);
        do_read(1'b0, 34'h0, 1);
        check("oor_discard", cap_d[0], 32'hBAD0BAD0);

        // Reset in the middle of an 8-beat read, with a backdoor write during reset.
        bd_write(1041, 32'h0);
        m_address = 34'h1000; m_burstcount = 5'd8; m_read1 = 1'b1;
        @(posedge clk); #1;
        m_read1 = 1'b0;
        nv = 0;
        for (int c = 0; c < 20 && nv < 2; c++) begin
            @(posedge clk); #1;
            if (valid1) nv++;
        end
        check("mid_pre_beats", 32'(nv), 32'd2);
        rst = 1'b1;
        bd_we = 1'b1; bd_err_we = 1'b1; bd_err = 1'b0;
        bd_index = 32'd1041; bd_data = 32'h77777777;
        @(posedge clk); #1;
        rst = 1'b0; bd_we = 1'b0; bd_err_we = 1'b0;
        check("mid_valid", 32'(valid1), 32'd0);
        check("mid_wait", 32'(wait1), 32'd0);
        check("mid_resp", 32'(resp1), 32'(RESP_DECODEERROR));
        check("mid_rdata", rdata1, 32'h0);
        check("mid_proto", 32'(perr1), 32'd0);
        check("mid_ecnt", 32'(ecnt1), 32'd0);
        nv = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (valid1) nv++;
        end
        check("mid_no_beats", 32'(nv), 32'd0);
        do_read(1'b0, 34'h1000, 1);
        check("mid_mem_intact", cap_d[0], 32'hDEADBEAF);
        do_read(1'b0, 34'h1044, 1);
        check("mid_bd_in_rst", cap_d[0], 32'h77777777);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_corvex_avalon_mem_model

// File: doc/corvex_avalon_mem_model.md
CORVEX_AVALON_MEM_MODEL -- requirements
Module: corvex_avalon_mem_model

Interface
REQ-001 SHALL have parameters: ADDR_W, default 34, byte-address width; DATA_W, default 32, data width (bytes = DATA_W/8).
REQ-002 SHALL have parameters: DEPTH_WORDS, default 32768, storage words; READ_LATENCY, default 1, range 1..8; BURST_W, default 5, burstcount width.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports m_address input ADDR_W, m_burstcount input BURST_W, m_read input 1, m_write input 1, m_writedata input DATA_W, m_byteenable input DATA_W/8.
REQ-006 SHALL have ports m_waitrequest output 1, m_readdata output DATA_W, m_readdatavalid output 1, m_response output 2.
REQ-007 SHALL have backdoor ports bd_we input 1, bd_index input 32 (word index), bd_data input DATA_W, bd_err_we input 1, bd_err input 1.
REQ-008 SHALL have status ports proto_err output 1 (sticky) and err_write_cnt output 16.

Function
REQ-009 SHALL implement states IDLE, RLAT, RBURST and WBURST.
REQ-010 IDLE: m_waitrequest SHALL be 0; m_read accepts a read burst and moves to RLAT; m_write accepts beat 0 of a write burst and moves to WBURST, or stays IDLE when burst length is 1.
REQ-011 Burst length SHALL be m_burstcount, with 0 treated as 1; beat k SHALL address word (m_address>>log2(DATA_W/8))+k, where m_address is latched at accept.
REQ-012 RLAT SHALL count READ_LATENCY-1 cycles, so the first m_readdatavalid occurs exactly READ_LATENCY cycles after the accept edge; RLAT is skipped when READ_LATENCY=1.
REQ-013 RBURST SHALL assert m_readdatavalid on consecutive cycles, one beat per cycle, then return to IDLE; m_waitrequest SHALL be 1 in RLAT and RBURST.
REQ-014 In WBURST, m_waitrequest SHALL be 0; each cycle with m_write high SHALL consume one beat; cycles with m_write low SHALL stall the burst; the last beat SHALL return to IDLE.
REQ-015 Writes SHALL update only the bytes whose m_byteenable bit is 1.
REQ-016 m_response per read beat: 2'b11 if the word index is >= DEPTH_WORDS; else 2'b10 if that word's error bit is set; else 2'b00.
REQ-017 m_readdata on error beats SHALL be 0.
REQ-018 Write beats to error or out-of-range words SHALL be discarded and SHALL increment err_write_cnt, saturating at 16'hFFFF.
REQ-019 When m_readdatavalid=0, m_response SHALL be 2'b11 and m_readdata SHALL hold its previous value.
REQ-020 m_read and m_write high together in IDLE, or m_read high in WBURST, SHALL set proto_err; IDLE then treats it as a read, and WBURST ignores m_read.
REQ-021 bd_we SHALL write bd_data to word bd_index in any state, taking priority over a bus write to the same word in the same cycle; bd_err_we SHALL set that word's error bit to bd_err.
REQ-022 A read beat issued in the cycle after a write to the same word SHALL return the new data.

Reset
REQ-023 rst SHALL force: state IDLE, m_readdatavalid 0, m_response 2'b11, m_readdata 0, proto_err 0, err_write_cnt 0, burst and latency counters 0.
REQ-024 rst in any state, including mid-burst, SHALL take effect at the next edge; no further beats of the aborted burst SHALL be produced.
REQ-025 Storage and the error map SHALL NOT be cleared by rst; backdoor writes SHALL remain functional during rst.

Configuration
REQ-026 With macro CORVEX_MEM_MODEL_ERRMAP_EN defined, the error map and REQ-016/018 error behaviour SHALL be present.
REQ-027 Without CORVEX_MEM_MODEL_ERRMAP_EN: no error map storage; bd_err_we is ignored; only the out-of-range 2'b11 response and the discard of out-of-range writes remain.

Structure
REQ-028 Response encodings (OKAY 2'b00, SLAVEERROR 2'b10, DECODEERROR 2'b11) and the state enum SHALL live in shared package corvex_mem_model_pkg.
REQ-029 Storage with per-byte write enable plus a backdoor port SHALL be sub-module corvex_mem_model_array; the FSM and counters SHALL stay in the top module.

Verification
REQ-030 Single read: word 1024 = 32'hDEADBEAF, READ_LATENCY=1, read at 0x1000, burstcount 1 -> readdatavalid one cycle after accept, data 32'hDEADBEAF, response 2'b00.
REQ-031 Latency/burst: READ_LATENCY=3, read burst of 4 at 0x2000 -> four consecutive beats, the first 3 cycles after accept; waitrequest=1 throughout; then IDLE.
REQ-032 Byte-enable write: write 32'h00ADBEAF with byteenable 4'b0011 to a word holding 32'hFFFFFFFF -> a later read returns 32'hFFFFBEAF.
REQ-033 Errors: error bit set on word 1025, read burst of 2 at 0x1000 -> responses 2'b00 then 2'b10; write to word 1025 -> err_write_cnt=1, contents unchanged; read at index DEPTH_WORDS -> 2'b11.
REQ-034 Reset mid-burst: rst during beat 2 of an 8-beat read -> readdatavalid=0 from the next edge, state IDLE, memory contents intact.
REQ-035 Protocol error: m_read and m_write high together in IDLE -> proto_err=1 and a read is performed; proto_err stays set until rst.
